// File: rtl/acq_pkg.sv
// acq_pkg: shared constants and the state encoding for the acquisition sequencer
package acq_pkg;
    localparam int NUM_CH = 16;
    localparam int DIV_W  = 8;
    localparam int WORD_W = 16;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int BIT_W  = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;
endpackage

// File: rtl/acq_tick_gen.sv
// acq_tick_gen: sample-tick divider; load latches divisor, tick fires once per divisor+1 enabled cycles
module acq_tick_gen
    import acq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] divisor,
    input  logic             enable,
    output logic             tick
);
    logic [DIV_W-1:0] div_l;
    logic [DIV_W-1:0] cnt;

    assign tick = enable && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_l <= '0;
            cnt   <= '0;
        end else if (load) begin
            div_l <= divisor;
            cnt   <= divisor;
        end else if (enable) begin
            cnt <= tick ? div_l : cnt - 1'b1;
        end
    end
endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: samples enabled channels on the divided tick and streams 16-sample words out per channel
module acq_sequencer
    import acq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acq_enable,
    input  logic [DIV_W-1:0]  clock_divisor,
    input  logic [NUM_CH-1:0] channel_enable,
    input  logic [NUM_CH-1:0] sample_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [CH_W-1:0]   out_chan,
    output logic              running,
    output logic              overflow
);
    state_t state, state_nx;
    logic [NUM_CH-1:0] en_l, pending, pending_nx, acc;
    logic [BIT_W-1:0] bitcnt;
    logic [NUM_CH-1:0][WORD_W-1:0] sr, sr_nx, bank;
    logic tick, load, live, word_done, overrun;

    assign load      = (state == IDLE) && acq_enable;
    // Dropping acq_enable stops ticking in that same cycle so the partial word is never extended
    assign live      = (state == RUN) && acq_enable;
    assign word_done = tick && (bitcnt == BIT_W'(WORD_W - 1));
    assign running   = (state == RUN);
    assign out_valid = (pending != '0);
    assign out_data  = bank[out_chan];
    assign acc        = (out_valid && out_ready) ? (NUM_CH'(1) << out_chan) : '0;
    assign pending_nx = pending & ~acc;
    // A handshake that empties pending in the load cycle is not an overrun
    assign overrun    = word_done && (pending_nx != '0);

    acq_tick_gen u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .divisor (clock_divisor),
        .enable  (live),
        .tick    (tick)
    );

    always_comb begin
        out_chan = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (pending[i]) out_chan = CH_W'(i);
    end

    always_comb begin
        sr_nx = sr;
        for (int i = 0; i < NUM_CH; i++)
            if (en_l[i]) sr_nx[i][bitcnt] = sample_in[i];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = acq_enable ? RUN : IDLE;
            RUN:     state_nx = !acq_enable ? ((pending_nx != '0) ? DRAIN : IDLE) : (overrun ? HALT : RUN);
            DRAIN:   state_nx = (pending_nx == '0) ? IDLE : DRAIN;
            HALT:    state_nx = acq_enable ? HALT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            en_l     <= '0;
            pending  <= '0;
            bitcnt   <= '0;
            sr       <= '0;
            bank     <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                en_l     <= channel_enable;
                bitcnt   <= '0;
                overflow <= 1'b0;
            end
            if (tick) begin
                sr     <= sr_nx;
                bitcnt <= bitcnt + 1'b1;
            end
            if (word_done) bank <= sr_nx;
            if (overrun) overflow <= 1'b1;
            pending <= ((state == HALT) || overrun) ? '0 : (word_done ? en_l : pending_nx);
        end
    end
endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: table-driven and directed checks of the acquisition sequencer
module tb_acq_sequencer;
    import acq_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              acq_enable = 1'b0;
    logic [DIV_W-1:0]  clock_divisor = '0;
    logic [NUM_CH-1:0] channel_enable = '0;
    logic [NUM_CH-1:0] sample_in = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic [CH_W-1:0]   out_chan;
    logic              running;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  div;
        logic [15:0] mask;
        logic [15:0] sin;
        int          lat;
        logic [3:0]  chan;
        logic [15:0] data;
    } vec_t;

    vec_t vt[5];

    acq_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .acq_enable     (acq_enable),
        .clock_divisor  (clock_divisor),
        .channel_enable (channel_enable),
        .sample_in      (sample_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_chan       (out_chan),
        .running        (running),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            tk();
            if (out_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic start(input logic [7:0] d, input logic [15:0] m);
        clock_divisor  = d;
        channel_enable = m;
        acq_enable     = 1'b1;
        tk();
    endtask

    task automatic stop_run(input string name);
        acq_enable = 1'b0;
        out_ready  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tk();
            if (!running && !out_valid) break;
        end
        chk(name, {running, out_valid}, 2'b00);
        tk();
    endtask

    task automatic run_toggle(input string name);
        logic s;
        out_ready = 1'b1;
        sample_in = '0;
        start(8'd0, 16'h0001);
        s = 1'b1;
        for (int k = 0; k < 16; k++) begin
            sample_in[0] = s;
            tk();
            s = ~s;
        end
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_data"}, out_data, 16'h5555);
        chk({name, "_chan"}, out_chan, 4'd0);
        chk({name, "_running"}, running, 1'b1);
        chk({name, "_overflow"}, overflow, 1'b0);
        stop_run({name, "_stop"});
    endtask

    initial begin
        int n;
        int seen;
        logic [15:0] sinv;

        vt[0] = '{8'd0, 16'h0001, 16'hFFFF, 16,  4'd0,  16'hFFFF};
        vt[1] = '{8'd3, 16'h8001, 16'h8000, 64,  4'd0,  16'h0000};
        vt[2] = '{8'd2, 16'h0010, 16'h0010, 48,  4'd4,  16'hFFFF};
        vt[3] = '{8'd5, 16'hF000, 16'h0000, 96,  4'd12, 16'h0000};
        vt[4] = '{8'd1, 16'h0300, 16'h0200, 32,  4'd8,  16'h0000};

        #12;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_running", running, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_data", out_data, 16'h0000);
        chk("rst_chan", out_chan, 4'd0);
        tk();
        rst_n = 1'b1;
        tk();

        run_toggle("toggle");

        for (int i = 0; i < 5; i++) begin
            sample_in = vt[i].sin;
            out_ready = 1'b1;
            start(vt[i].div, vt[i].mask);
            chk($sformatf("vec%0d_running", i), running, 1'b1);
            wait_valid(5000, n);
            chk($sformatf("vec%0d_latency", i), n, vt[i].lat);
            chk($sformatf("vec%0d_chan", i), out_chan, vt[i].chan);
            chk($sformatf("vec%0d_data", i), out_data, vt[i].data);
            stop_run($sformatf("vec%0d_stop", i));
        end

        // mask 0x8001: second word of the pair and the next pair 64 cycles later
        sample_in = 16'h8000;
        out_ready = 1'b1;
        start(8'd3, 16'h8001);
        wait_valid(200, n);
        chk("pair_first_chan", out_chan, 4'd0);
        tk();
        chk("pair_second_chan", out_chan, 4'd15);
        chk("pair_second_data", out_data, 16'hFFFF);
        wait_valid(200, n);
        chk("pair_period", n, 63);
        chk("pair_next_chan", out_chan, 4'd0);
        stop_run("pair_stop");

        // zero mask keeps ticking without producing words
        start(8'd0, 16'h0000);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tk();
            if (out_valid) seen++;
        end
        chk("zero_mask_words", seen, 0);
        chk("zero_mask_running", running, 1'b1);
        stop_run("zero_mask_stop");

        // full mask at divisor 0 with continuous ready, then a one-cycle stall overruns
        sinv = 16'hA5A5;
        sample_in = sinv;
        out_ready = 1'b1;
        start(8'd0, 16'hFFFF);
        wait_valid(100, n);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("full_chan%0d", j), out_chan, j[3:0]);
            chk($sformatf("full_data%0d", j), out_data, {16{sinv[j]}});
            tk();
        end
        chk("full_reload_valid", out_valid, 1'b1);
        chk("full_no_overflow", overflow, 1'b0);
        out_ready = 1'b0;
        tk();
        out_ready = 1'b1;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            tk();
            if (overflow) begin
                n = k;
                break;
            end
        end
        chk("ovf_timeout", n > 0, 1'b1);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_valid", out_valid, 1'b0);
        chk("ovf_running", running, 1'b0);
        acq_enable = 1'b0;
        tk();
        tk();
        chk("ovf_idle_sticky", overflow, 1'b1);
        start(8'd0, 16'h0001);
        chk("ovf_cleared_on_start", overflow, 1'b0);
        stop_run("ovf_stop");

        // stall: divisor 9, two channels, ready low for five cycles
        sample_in = 16'h0002;
        out_ready = 1'b0;
        start(8'd9, 16'h0003);
        wait_valid(300, n);
        chk("stall_latency", n, 160);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_chan%0d", k), out_chan, 4'd0);
            chk($sformatf("stall_data%0d", k), out_data, 16'h0000);
            tk();
        end
        out_ready = 1'b1;
        tk();
        chk("stall_second_chan", out_chan, 4'd1);
        chk("stall_second_data", out_data, 16'hFFFF);
        tk();
        chk("stall_empty", out_valid, 1'b0);
        wait_valid(300, n);
        chk("stall_reload_chan", out_chan, 4'd0);
        chk("stall_no_overflow", overflow, 1'b0);
        stop_run("stall_stop");

        // drop enable at bitcnt 7 with two words pending; mask change mid-run ignored
        sample_in = 16'h0003;
        out_ready = 1'b0;
        start(8'd0, 16'h0003);
        channel_enable = 16'hFFFF;
        wait_valid(100, n);
        for (int k = 0; k < 7; k++) tk();
        acq_enable = 1'b0;
        tk();
        chk("drain_running", running, 1'b0);
        chk("drain_valid", out_valid, 1'b1);
        chk("drain_chan0", out_chan, 4'd0);
        out_ready = 1'b1;
        tk();
        chk("drain_chan1", out_chan, 4'd1);
        chk("drain_data1", out_data, 16'hFFFF);
        tk();
        chk("drain_done", out_valid, 1'b0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tk();
            if (out_valid || running) seen++;
        end
        chk("drain_no_partial", seen, 0);
        channel_enable = 16'h0000;

        // asynchronous reset mid-run with a word waiting
        sample_in = 16'h0001;
        out_ready = 1'b0;
        start(8'd0, 16'h0001);
        wait_valid(100, n);
        chk("arst_pre_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_running", running, 1'b0);
        chk("arst_overflow", overflow, 1'b0);
        acq_enable = 1'b0;
        tk();
        rst_n = 1'b1;
        tk();
        run_toggle("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Sequences one acquisition run from the register-file controls `acq_enable`, `clock_divisor` and `channel_enable`.
- Generates the sample tick from the divisor and shifts each enabled channel's input bit into a per-channel 16-bit word.
- After every 16 ticks, hands the completed words to a downstream FIFO/USB packer over a valid/ready stream, one word per enabled channel in ascending channel order.
- Detects output-bank overrun and halts the run.

Parameters:
- NUM_CH, 16, number of logic input channels (channel index width CH_W = clog2(NUM_CH) = 4).
- DIV_W, 8, width of the sample-rate divisor.
- WORD_W, 16, samples per channel word; must be a power of two.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- acq_enable  in  1  run request from the status/control register; level-sensitive.
- clock_divisor  in  DIV_W  sample period minus one, in clk cycles.
- channel_enable  in  NUM_CH  per-channel enable mask.
- sample_in  in  NUM_CH  synchronised channel inputs, sampled on tick.
- out_valid  out  1  word available.
- out_ready  in  1  downstream accepts word.
- out_data  out  WORD_W  channel word; bit k is the k-th sample of that word.
- out_chan  out  CH_W  channel index of out_data.
- running  out  1  state == RUN.
- overflow  out  1  sticky overrun flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0.
  - Shift registers, bank and pending mask cleared.
  - Divider and bit counters cleared.
- States: IDLE, RUN, DRAIN, HALT.
- IDLE: if acq_enable=1 at edge T, then at T+1:
  - state=RUN, overflow=0.
  - div_l<=clock_divisor, en_l<=channel_enable, cnt<=clock_divisor, bitcnt<=0.
  - Config inputs are ignored for the rest of the run.
- RUN tick generation:
  - tick = (cnt==0).
  - On tick, cnt<=div_l; otherwise cnt<=cnt-1.
  - divisor 0 gives a tick every cycle starting at T+1; divisor D gives one tick per D+1 cycles.
- RUN sampling on each tick:
  - sr[i][bitcnt]<=sample_in[i] for every i with en_l[i]=1; disabled channels' sr is don't-care.
  - bitcnt increments and wraps at WORD_W.
- Word completion, on the tick where bitcnt==WORD_W-1:
  - bank<=sr, with the current sample merged in.
  - pending<=en_l.
- Overrun:
  - If at the load cycle (pending & ~accepted_this_cycle)!=0, then overflow<=1 and state<=HALT.
  - A handshake that clears the last pending bit in the load cycle is not an overrun; the load wins.
- Zero channel mask: en_l==0 keeps RUN ticking and produces no words.
- Output stream:
  - out_valid=(pending!=0); out_chan=index of the lowest set bit of pending; out_data=bank[out_chan].
  - On out_valid&out_ready, clear that pending bit; the next word is presented the following cycle.
  - out_data and out_chan are stable while out_valid&!out_ready.
- acq_enable=0 in RUN:
  - Go to DRAIN if pending!=0, else IDLE.
  - The partial word (bitcnt samples) is discarded; no ticks occur after leaving RUN.
- DRAIN: emit the remaining pending words; go to IDLE when pending becomes 0. acq_enable is ignored until IDLE.
- HALT:
  - pending cleared, out_valid=0, overflow held at 1.
  - Go to IDLE when acq_enable=0.
  - overflow stays 1 in IDLE until the next RUN start.
- running=1 only in RUN.
- No combinational path from out_ready to out_valid.

Decomposition:
- Shared package acq_pkg:
  - state enum {IDLE, RUN, DRAIN, HALT}.
  - NUM_CH, WORD_W, DIV_W and CH_W constants.
- Sub-module acq_tick_gen holds the divider counter:
  - inputs: load, divisor, enable.
  - output: tick.
- The priority encoder for pending stays inline.

Test Plan:
- Divisor 0, mask 0x0001, sample_in[0] toggling 1,0,1,..., ready=1: after 16 cycles, one word 0x5555 with chan 0; running=1; overflow=0.
- Divisor 3, mask 0x8001, ch15 constant 1, ch0 constant 0: first words appear 64 cycles after start, in order chan0=0x0000 then chan15=0xFFFF; then a new pair every 64 cycles.
- Divisor 0, mask 0xFFFF, out_ready=1 continuous: 16 words per 16 cycles with no overflow. Then hold ready=0 for 1 cycle: overflow=1, state HALT, out_valid=0.
- Stall: divisor 9, mask 0x0003, ready=0 for 5 cycles while valid: out_data and out_chan are held constant; both words are delivered before the next load; no overflow.
- Drop acq_enable at bitcnt=7 while 2 words are pending: state DRAIN, both words delivered, then IDLE; no partial word emitted. Change channel_enable mid-run: no effect until the next start.
- Assert rst_n=0 mid-RUN with valid=1: out_valid, running and overflow are 0 immediately (asynchronously). A restart after reset behaves like the first scenario.
